// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction-memory request handshake, one-entry
// hold buffer and the IF/ID pipeline register.
module fetch_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemAck,
  input  logic [31:0]     ImemRdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  typedef enum logic [1:0] {
    S_REQ,
    S_DROP,
    S_HOLD
  } state_t;

  state_t          state, state_n;
  logic [XLEN-1:0] pc_f, pc_n;
  logic [XLEN-1:0] req_addr, req_n;
  logic [31:0]     buf_instr, buf_instr_n;
  logic [XLEN-1:0] buf_pc, buf_pc_n;
  logic            hold;

  // Value IF/ID takes when it is neither flushed nor held; a bubble unless a
  // state rule supplies a real instruction.
  logic [31:0]     ifid_instr_n;
  logic [XLEN-1:0] ifid_pc_n;
  logic [XLEN-1:0] ifid_pc4_n;
  logic            ifid_valid_n;

  assign hold     = StallF | StallD;
  assign ImemReq  = rst_n && (state != S_HOLD);
  assign ImemAddr = req_addr;

  // Next-state, PC/request-address and IF/ID load selection.
  always_comb begin
    state_n      = state;
    pc_n         = pc_f;
    req_n        = req_addr;
    buf_instr_n  = buf_instr;
    buf_pc_n     = buf_pc;
    ifid_instr_n = NOP_INSTR;
    ifid_pc_n    = '0;
    ifid_pc4_n   = '0;
    ifid_valid_n = 1'b0;

    unique case (state)
      S_REQ: begin
        if (PCSrcE) begin
          pc_n = PCTargetE;
          if (ImemAck) req_n   = PCTargetE;
          else         state_n = S_DROP;
        end else if (ImemAck && !hold) begin
          ifid_instr_n = ImemRdata;
          ifid_pc_n    = req_addr;
          ifid_pc4_n   = req_addr + XLEN'(4);
          ifid_valid_n = 1'b1;
          pc_n         = pc_f + XLEN'(4);
          req_n        = pc_f + XLEN'(4);
        end else if (ImemAck) begin
          buf_instr_n = ImemRdata;
          buf_pc_n    = req_addr;
          pc_n        = pc_f + XLEN'(4);
          state_n     = S_HOLD;
        end
      end
      S_DROP: begin
        // A repeated redirect updates PCF first so the ack picks it up.
        if (PCSrcE) pc_n = PCTargetE;
        if (ImemAck) begin
          req_n   = PCSrcE ? PCTargetE : pc_f;
          state_n = S_REQ;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pc_n    = PCTargetE;
          req_n   = PCTargetE;
          state_n = S_REQ;
        end else if (!hold) begin
          ifid_instr_n = buf_instr;
          ifid_pc_n    = buf_pc;
          ifid_pc4_n   = buf_pc + XLEN'(4);
          ifid_valid_n = 1'b1;
          req_n        = pc_f;
          state_n      = S_REQ;
        end
      end
      default: state_n = S_REQ;
    endcase
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc_f      <= RESET_PC;
      req_addr  <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_pc    <= '0;
    end else begin
      state     <= state_n;
      pc_f      <= pc_n;
      req_addr  <= req_n;
      buf_instr <= buf_instr_n;
      buf_pc    <= buf_pc_n;
    end
  end

  // IF/ID register: flush beats hold beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!hold) begin
      InstrD   <= ifid_instr_n;
      PCD      <= ifid_pc_n;
      PCPlus4D <= ifid_pc4_n;
      ValidD   <= ifid_valid_n;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle table, reset-abort sequence and a
// randomized run against a program-order reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemAck = 1'b0;
  logic [31:0] ImemRdata = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  int total = 0;
  int bad   = 0;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemAck(ImemAck),
    .ImemRdata(ImemRdata), .InstrD(InstrD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  always #5 clk = ~clk;

  // Address-tagged instruction word returned by the memory model.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ 32'h5A00_0003;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        st, fl, br, ack;
    logic [31:0] tgt;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_instr, e_pcd, e_pc4;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic fl, input logic br,
                              input logic [31:0] tgt, input logic ack,
                              input logic e_req, input logic [31:0] e_addr,
                              input logic e_valid, input logic [31:0] e_pcd,
                              input logic [31:0] e_pc4);
    vec_t v;
    v.st = st; v.fl = fl; v.br = br; v.tgt = tgt; v.ack = ack;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_pcd = e_pcd; v.e_pc4 = e_pc4;
    v.e_instr = e_valid ? word_at(e_pcd) : NOP;
    return v;
  endfunction

  vec_t vec [20];

  // Random-phase model state.
  logic [31:0] expect_pc, lat_addr, tgt;
  bit          busy, redirect, st;
  int unsigned cnt, idle;

  initial begin
    // Each row: inputs for one cycle, and the outputs visible during it.
    vec[0]  = mk(0,0,0,32'h0,1,        1,32'h0,        0,32'h0,32'h0);
    vec[1]  = mk(0,0,0,32'h0,1,        1,32'h4,        1,32'h0,32'h4);
    vec[2]  = mk(1,0,0,32'h0,1,        1,32'h8,        1,32'h4,32'h8);
    vec[3]  = mk(1,0,0,32'h0,0,        0,32'h8,        1,32'h4,32'h8);
    vec[4]  = mk(1,0,0,32'h0,0,        0,32'h8,        1,32'h4,32'h8);
    vec[5]  = mk(0,0,0,32'h0,0,        0,32'h8,        1,32'h4,32'h8);
    vec[6]  = mk(0,0,0,32'h0,1,        1,32'hC,        1,32'h8,32'hC);
    vec[7]  = mk(0,1,1,32'h100,0,      1,32'h10,       1,32'hC,32'h10);
    vec[8]  = mk(0,0,0,32'h0,0,        1,32'h10,       0,32'h0,32'h0);
    vec[9]  = mk(0,0,0,32'h0,1,        1,32'h10,       0,32'h0,32'h0);
    vec[10] = mk(0,0,0,32'h0,1,        1,32'h100,      0,32'h0,32'h0);
    vec[11] = mk(1,1,1,32'h200,1,      1,32'h104,      1,32'h100,32'h104);
    vec[12] = mk(0,0,0,32'h0,0,        1,32'h200,      0,32'h0,32'h0);
    vec[13] = mk(0,0,0,32'h0,0,        1,32'h200,      0,32'h0,32'h0);
    vec[14] = mk(0,0,0,32'h0,1,        1,32'h200,      0,32'h0,32'h0);
    vec[15] = mk(0,1,1,32'hFFFF_FFFC,0,1,32'h204,      1,32'h200,32'h204);
    vec[16] = mk(0,0,0,32'h0,1,        1,32'h204,      0,32'h0,32'h0);
    vec[17] = mk(0,0,0,32'h0,1,        1,32'hFFFF_FFFC,0,32'h0,32'h0);
    vec[18] = mk(0,0,0,32'h0,1,        1,32'h0,        1,32'hFFFF_FFFC,32'h0);
    vec[19] = mk(0,0,0,32'h0,0,        1,32'h4,        1,32'h0,32'h4);

    // Reset state.
    #12;
    chk("rst_req", {31'b0, ImemReq}, 32'h0);
    chk("rst_valid", {31'b0, ValidD}, 32'h0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_addr", ImemAddr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cycle table.
    for (int unsigned i = 0; i < 20; i++) begin
      StallF = vec[i].st; StallD = vec[i].st; FlushD = vec[i].fl;
      PCSrcE = vec[i].br; PCTargetE = vec[i].tgt;
      ImemAck = vec[i].ack;
      ImemRdata = vec[i].ack ? word_at(vec[i].e_addr) : 32'hDEAD_BEEF;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, ImemReq}, {31'b0, vec[i].e_req});
      chk($sformatf("v%0d_addr", i), ImemAddr, vec[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'b0, ValidD}, {31'b0, vec[i].e_valid});
      chk($sformatf("v%0d_instr", i), InstrD, vec[i].e_instr);
      if (vec[i].e_valid) begin
        chk($sformatf("v%0d_pcd", i), PCD, vec[i].e_pcd);
        chk($sformatf("v%0d_pc4", i), PCPlus4D, vec[i].e_pc4);
      end
      @(negedge clk);
    end

    // Reset while the request to 0x4 is still outstanding.
    StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0; ImemAck = 0;
    rst_n = 1'b0;
    #1;
    chk("abort_req", {31'b0, ImemReq}, 32'h0);
    chk("abort_valid", {31'b0, ValidD}, 32'h0);
    chk("abort_instr", InstrD, NOP);
    chk("abort_addr", ImemAddr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("abort_restart_req", {31'b0, ImemReq}, 32'h1);
    chk("abort_restart_addr", ImemAddr, 32'h0);

    // Randomized run: the memory answers each request after 0..3 wait
    // cycles; decode consumes IF/ID whenever it is not stalled. Every
    // consumed instruction must be the next one in program order.
    expect_pc = 32'h0; busy = 0; cnt = 0; idle = 0;
    for (int unsigned c = 0; c < 4000; c++) begin
      @(negedge clk);
      redirect = ($urandom_range(0, 24) == 0);
      st       = ($urandom_range(0, 3) == 0);
      tgt      = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'h0000_FFFC);
      StallF = st; StallD = st; PCSrcE = redirect; FlushD = redirect;
      PCTargetE = tgt;
      if (redirect) begin
        expect_pc = tgt;
        idle = 0;
      end else if (!st && ValidD) begin
        chk("rnd_pcd", PCD, expect_pc);
        chk("rnd_instr", InstrD, word_at(expect_pc));
        chk("rnd_pc4", PCPlus4D, expect_pc + 32'd4);
        expect_pc = expect_pc + 32'd4;
        idle = 0;
      end else begin
        idle++;
      end
      if (idle > 200) begin
        chk("rnd_progress", idle, 0);
        break;
      end
      if (ImemReq) begin
        if (!busy) begin
          busy = 1; lat_addr = ImemAddr; cnt = $urandom_range(0, 3);
        end else begin
          chk("rnd_addr_stable", ImemAddr, lat_addr);
        end
        ImemAck   = (cnt == 0);
        ImemRdata = (cnt == 0) ? word_at(lat_addr) : $urandom;
      end else begin
        if (busy) chk("rnd_req_dropped", {31'b0, ImemReq}, 32'h1);
        busy = 0;
        ImemAck = 0;
      end
      @(posedge clk);
      if (ImemAck) busy = 0;
      else if (busy) cnt--;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RISC-V pipeline: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register.
- Consumes the hazard controls StallF, StallD and FlushD, plus the EX redirect PCSrcE/PCTargetE.
- Produces InstrD/PCD/PCPlus4D, from which decode derives the Rs1D/Rs2D sent back to the hazard unit.
- Tolerates a variable-latency instruction memory and holds one instruction when decode is stalled.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PCF value after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
StallF  in  1  hazard unit: hold fetch
StallD  in  1  hazard unit: hold IF/ID
FlushD  in  1  hazard unit: clear IF/ID
PCSrcE  in  1  taken branch/jump resolved in EX
PCTargetE  in  XLEN  redirect target
ImemReq  out  1  instruction read request
ImemAddr  out  XLEN  request address
ImemAck  in  1  response valid this cycle, sampled at clk edge
ImemRdata  in  32  instruction word, valid with ImemAck
InstrD  out  32  IF/ID instruction
PCD  out  XLEN  IF/ID PC
PCPlus4D  out  XLEN  IF/ID PC+4
ValidD  out  1  IF/ID holds a real instruction

Behaviour:
- Hold = StallF | StallD. Both are driven identically by the hazard unit, and this block treats them as one condition.
- Registers: PCF, ReqAddr (drives ImemAddr), state, BufInstr, BufPC, IF/ID set.
- Reset (rst_n=0, async):
  - PCF=ReqAddr=RESET_PC, state=REQ.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - ImemReq forced 0 while rst_n=0.
  - Reset mid-transaction aborts it. Any late ack is not expected, because memory shares the reset.
- ImemReq=1 in REQ and DROP, 0 in HOLD. ImemAddr=ReqAddr at all times and stays stable until ImemAck.
- State REQ:
  - PCSrcE=1: PCF<=PCTargetE, ImemRdata discarded.
    - If ImemAck: ReqAddr<=PCTargetE, stay REQ.
    - Otherwise go to DROP.
  - ImemAck & !Hold: IF/ID<={ImemRdata, ReqAddr, ReqAddr+4, 1}, PCF<=PCF+4, ReqAddr<=PCF+4, stay REQ. Back-to-back fetch gives 1 instr/cycle with zero-wait memory.
  - ImemAck & Hold: BufInstr<=ImemRdata, BufPC<=ReqAddr, PCF<=PCF+4, go to HOLD.
  - No ack & !Hold: IF/ID loads a bubble (NOP_INSTR, ValidD=0).
- State DROP: completes the stale request and discards its data.
  - ImemAck: ReqAddr<=PCF, go to REQ.
  - PCSrcE=1 again: PCF<=PCTargetE, applied before the ack rule.
- State HOLD:
  - PCSrcE=1: buffer discarded, PCF<=PCTargetE, ReqAddr<=PCTargetE, go to REQ.
  - Otherwise, if !Hold: IF/ID<={BufInstr, BufPC, BufPC+4, 1}, ReqAddr<=PCF, go to REQ.
- IF/ID priority, highest first:
  - FlushD: bubble.
  - Hold: keep current contents.
  - Load per state rules.
  - FlushD outranks StallD when both are set.
- Latency: address presented in cycle N, ack in cycle N+k (k≥0 cycles of wait), instruction visible on InstrD after the edge that samples the ack.
- Arithmetic: PC+4 wraps modulo 2^XLEN, with no trap. PCTargetE bits [1:0] are used as given; alignment checking is not done here.
- An instruction is never delivered twice and never lost: each acked, non-killed word reaches IF/ID exactly once, in program order.

Test Plan:
- Reset, then ImemAck tied 1 with Rdata=addr-tagged words: ImemAddr 0,4,8,...; InstrD follows one cycle later; ValidD=1 from the 2nd edge onward; ValidD=0 during reset.
- Ack delayed 2 cycles per request: ImemAddr held 3 cycles each; IF/ID gets 2 bubbles (ValidD=0, InstrD=0x00000013) between real instructions.
- StallD=StallF=1 for 3 cycles on an ack at addr 0x8: state HOLD, ImemReq=0, IF/ID unchanged. On release, InstrD=word@0x8, PCD=0x8, and the next request is 0xC.
- PCSrcE=1, PCTargetE=0x100 while a request to 0x10 is pending (ack 2 cycles later): 0x10 data never reaches InstrD. The next request is 0x100, and ImemAddr stays 0x10 until its ack.
- FlushD=1 and StallD=1 together: IF/ID becomes a bubble (ValidD=0). PCSrcE=1 with a simultaneous ack: the next ImemAddr is the target and the acked word is dropped.
- PCF=0xFFFFFFFC with zero-wait ack: next ImemAddr=0x00000000 and PCPlus4D=0x00000000.
